// File: rtl/gesummv.sv
// gesummv: y = alpha*A*x + beta*B*x and tmp = A*x over 8x8 matrices, one row every 10 cycles
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   t                         start pulse (ignored unless idle)
//   alpha, beta               32-bit scalar coefficients, stable during a run
//   A_p0_* / B_p0_*           matrix read ports, address 8*i+j, data one cycle after the enable
//   X_p0_*                    vector read port, address j
//   tmp_p0_* / Y_p0_*         result write ports, address i, written at the edge where enable is high
module gesummv (
    input  logic        clk,
    input  logic        rst,
    input  logic        t,
    input  logic [31:0] alpha,
    input  logic [31:0] beta,
    output logic [5:0]  A_p0_addr_data,
    output logic        A_p0_addr_en,
    output logic        A_p0_rd_en,
    input  logic [31:0] A_p0_rd_data,
    output logic [5:0]  B_p0_addr_data,
    output logic        B_p0_addr_en,
    output logic        B_p0_rd_en,
    input  logic [31:0] B_p0_rd_data,
    output logic [2:0]  X_p0_addr_data,
    output logic        X_p0_addr_en,
    output logic        X_p0_rd_en,
    input  logic [31:0] X_p0_rd_data,
    output logic [2:0]  tmp_p0_addr_data,
    output logic        tmp_p0_addr_en,
    output logic        tmp_p0_wr_en,
    output logic [31:0] tmp_p0_wr_data,
    output logic [2:0]  Y_p0_addr_data,
    output logic        Y_p0_addr_en,
    output logic        Y_p0_wr_en,
    output logic [31:0] Y_p0_wr_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t      state_q;
    logic [2:0]  i_q, j_q;
    logic        wph_q, pend_q, rd_q, wr_q;
    logic [31:0] acc_a_q, acc_b_q, tmp_q, y_q;
    logic [31:0] acc_a_d, acc_b_d, y_d;
    // pend_q marks that read data requested last cycle is on the rd_data buses now
    always_comb begin
        acc_a_d = pend_q ? acc_a_q + A_p0_rd_data * X_p0_rd_data : acc_a_q;
        acc_b_d = pend_q ? acc_b_q + B_p0_rd_data * X_p0_rd_data : acc_b_q;
        y_d     = alpha * acc_a_d + beta * acc_b_d;
    end
    assign A_p0_addr_data   = {i_q, j_q};
    assign A_p0_addr_en     = rd_q;
    assign A_p0_rd_en       = rd_q;
    assign B_p0_addr_data   = {i_q, j_q};
    assign B_p0_addr_en     = rd_q;
    assign B_p0_rd_en       = rd_q;
    assign X_p0_addr_data   = j_q;
    assign X_p0_addr_en     = rd_q;
    assign X_p0_rd_en       = rd_q;
    assign tmp_p0_addr_data = i_q;
    assign tmp_p0_addr_en   = wr_q;
    assign tmp_p0_wr_en     = wr_q;
    assign tmp_p0_wr_data   = tmp_q;
    assign Y_p0_addr_data   = i_q;
    assign Y_p0_addr_en     = wr_q;
    assign Y_p0_wr_en       = wr_q;
    assign Y_p0_wr_data     = y_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 3'd0;
            j_q     <= 3'd0;
            wph_q   <= 1'b0;
            pend_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            acc_a_q <= 32'd0;
            acc_b_q <= 32'd0;
            tmp_q   <= 32'd0;
            y_q     <= 32'd0;
        end else begin
            pend_q  <= rd_q;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            wr_q    <= 1'b0;
            case (state_q)
                IDLE: if (t) begin
                    state_q <= READ;
                    i_q     <= 3'd0;
                    j_q     <= 3'd0;
                    rd_q    <= 1'b1;
                    acc_a_q <= 32'd0;
                    acc_b_q <= 32'd0;
                end
                READ: if (j_q == 3'd7) begin
                    state_q <= WRITE;
                    rd_q    <= 1'b0;
                    wph_q   <= 1'b0;
                end else begin
                    j_q <= j_q + 3'd1;
                end
                // first WRITE cycle folds in the last term and registers results;
                // second cycle presents them on the write ports
                WRITE: if (!wph_q) begin
                    wph_q <= 1'b1;
                    wr_q  <= 1'b1;
                    tmp_q <= acc_a_d;
                    y_q   <= y_d;
                end else if (i_q == 3'd7) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= READ;
                    i_q     <= i_q + 3'd1;
                    j_q     <= 3'd0;
                    rd_q    <= 1'b1;
                    acc_a_q <= 32'd0;
                    acc_b_q <= 32'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gesummv.sv
// tb_gesummv: directed table-driven bench for gesummv with memory models
module tb_gesummv;
    logic        clk = 0, rst = 1, t = 0, clr = 0;
    logic [31:0] alpha = 1, beta = 1;
    logic [5:0]  A_p0_addr_data, B_p0_addr_data;
    logic        A_p0_addr_en, A_p0_rd_en, B_p0_addr_en, B_p0_rd_en, X_p0_addr_en, X_p0_rd_en;
    logic [2:0]  X_p0_addr_data, tmp_p0_addr_data, Y_p0_addr_data;
    logic [31:0] A_p0_rd_data, B_p0_rd_data, X_p0_rd_data, tmp_p0_wr_data, Y_p0_wr_data;
    logic        tmp_p0_addr_en, tmp_p0_wr_en, Y_p0_addr_en, Y_p0_wr_en;
    logic [31:0] a_mem [64], b_mem [64], x_mem [8], tmp_mem [8], y_mem [8];
    logic [31:0] a_rd = 0, b_rd = 0, x_rd = 0;
    int          ntmp = 0, ny = 0;
    logic [2:0]  ta = 0, ya = 0;
    logic        ord_err = 0;
    int          total = 0, bad = 0;
    int          first_rd, first_wr, last_wr;
    logic [5:0]  first_addr;
    logic [2:0]  last_addr;
    logic        idle_bad;
    typedef struct {
        logic [31:0] alpha, beta, y0, ys;
    } vec_t;
    vec_t vecs [5];

    gesummv dut (
        .clk(clk), .rst(rst), .t(t), .alpha(alpha), .beta(beta),
        .A_p0_addr_data(A_p0_addr_data), .A_p0_addr_en(A_p0_addr_en), .A_p0_rd_en(A_p0_rd_en), .A_p0_rd_data(A_p0_rd_data),
        .B_p0_addr_data(B_p0_addr_data), .B_p0_addr_en(B_p0_addr_en), .B_p0_rd_en(B_p0_rd_en), .B_p0_rd_data(B_p0_rd_data),
        .X_p0_addr_data(X_p0_addr_data), .X_p0_addr_en(X_p0_addr_en), .X_p0_rd_en(X_p0_rd_en), .X_p0_rd_data(X_p0_rd_data),
        .tmp_p0_addr_data(tmp_p0_addr_data), .tmp_p0_addr_en(tmp_p0_addr_en), .tmp_p0_wr_en(tmp_p0_wr_en), .tmp_p0_wr_data(tmp_p0_wr_data),
        .Y_p0_addr_data(Y_p0_addr_data), .Y_p0_addr_en(Y_p0_addr_en), .Y_p0_wr_en(Y_p0_wr_en), .Y_p0_wr_data(Y_p0_wr_data)
    );

    always #5 clk = ~clk;
    assign A_p0_rd_data = a_rd;
    assign B_p0_rd_data = b_rd;
    assign X_p0_rd_data = x_rd;

    always @(posedge clk) begin
        if (A_p0_rd_en) a_rd <= a_mem[A_p0_addr_data];
        if (B_p0_rd_en) b_rd <= b_mem[B_p0_addr_data];
        if (X_p0_rd_en) x_rd <= x_mem[X_p0_addr_data];
        if (clr) begin
            ntmp <= 0; ny <= 0; ta <= 0; ya <= 0; ord_err <= 0;
            for (int k = 0; k < 8; k++) begin
                tmp_mem[k] <= 32'hDEADBEEF;
                y_mem[k]   <= 32'hDEADBEEF;
            end
        end else begin
            if (tmp_p0_wr_en) begin
                tmp_mem[tmp_p0_addr_data] <= tmp_p0_wr_data;
                ntmp <= ntmp + 1;
                if (tmp_p0_addr_data != ta) ord_err <= 1;
                ta <= ta + 3'd1;
            end
            if (Y_p0_wr_en) begin
                y_mem[Y_p0_addr_data] <= Y_p0_wr_data;
                ny <= ny + 1;
                if (Y_p0_addr_data != ya) ord_err <= 1;
                ya <= ya + 3'd1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero_outs(input string nm);
        chk({nm, "_en"}, {31'd0, A_p0_addr_en | A_p0_rd_en | B_p0_addr_en | B_p0_rd_en | X_p0_addr_en | X_p0_rd_en
                          | tmp_p0_addr_en | tmp_p0_wr_en | Y_p0_addr_en | Y_p0_wr_en}, 32'd0);
        chk({nm, "_addr"}, {17'd0, A_p0_addr_data, B_p0_addr_data, X_p0_addr_data}, 32'd0);
        chk({nm, "_waddr"}, {26'd0, tmp_p0_addr_data, Y_p0_addr_data}, 32'd0);
        chk({nm, "_tdata"}, tmp_p0_wr_data, 32'd0);
        chk({nm, "_ydata"}, Y_p0_wr_data, 32'd0);
    endtask

    task automatic fill_seq();
        for (int k = 0; k < 64; k++) begin
            a_mem[k] = 32'(k + 1);
            b_mem[k] = 32'(k + 1);
        end
        for (int k = 0; k < 8; k++) x_mem[k] = 32'(k + 1);
    endtask

    // cycle 0 is the cycle t is high; iteration c samples at the negedge of cycle c
    task automatic run(input int t2, input int rst_at);
        first_rd = -1; first_wr = -1; last_wr = -1; first_addr = 0; last_addr = 0; idle_bad = 0;
        @(negedge clk); clr = 1; t = 1;
        @(negedge clk); clr = 0; t = 0;
        for (int c = 1; c <= 86; c++) begin
            if (c == rst_at) begin
                #1 rst = 1;
                #1 chk_zero_outs("rst_async");
                @(negedge clk); @(negedge clk);
                rst = 0;
                repeat (15) @(negedge clk);
                return;
            end
            if (A_p0_rd_en && first_rd < 0) begin
                first_rd = c;
                first_addr = A_p0_addr_data;
            end
            if (tmp_p0_wr_en) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                last_addr = tmp_p0_addr_data;
            end
            if (c >= 81 && (A_p0_rd_en | B_p0_rd_en | X_p0_rd_en | tmp_p0_wr_en | Y_p0_wr_en)) idle_bad = 1;
            t = (c == t2);
            @(negedge clk);
        end
        t = 0;
    endtask

    task automatic chk_run(input logic [31:0] t0, input logic [31:0] ts, input logic [31:0] y0, input logic [31:0] ys);
        chk("ntmp", 32'(ntmp), 32'd8);
        chk("ny", 32'(ny), 32'd8);
        chk("order", {31'd0, ord_err}, 32'd0);
        chk("first_rd_cyc", 32'(first_rd), 32'd1);
        chk("first_rd_addr", {26'd0, first_addr}, 32'd0);
        chk("first_wr_cyc", 32'(first_wr), 32'd10);
        chk("last_wr_cyc", 32'(last_wr), 32'd80);
        chk("last_wr_addr", {29'd0, last_addr}, 32'd7);
        chk("idle_after", {31'd0, idle_bad}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tmp[%0d]", i), tmp_mem[i], t0 + ts * 32'(i));
            chk($sformatf("y[%0d]", i), y_mem[i], y0 + ys * 32'(i));
        end
    endtask

    initial begin
        vecs[0] = '{32'd1, 32'd1, 32'd408, 32'd576};
        vecs[1] = '{32'd2, 32'd0, 32'd408, 32'd576};
        vecs[2] = '{32'd0, 32'd3, 32'd612, 32'd864};
        vecs[3] = '{32'd3, 32'd2, 32'd1020, 32'd1440};
        vecs[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
        fill_seq();
        repeat (3) @(negedge clk);
        chk_zero_outs("reset");
        t = 1;
        @(negedge clk);
        t = 0;
        rst = 0;
        repeat (3) @(negedge clk);
        chk("t_in_rst", {31'd0, A_p0_rd_en}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            alpha = vecs[v].alpha;
            beta  = vecs[v].beta;
            run(-1, -1);
            chk_run(32'd204, 32'd288, vecs[v].y0, vecs[v].ys);
        end

        alpha = 1; beta = 1;
        run(40, -1);
        chk_run(32'd204, 32'd288, 32'd408, 32'd576);

        run(-1, 25);
        chk("rst_ntmp", 32'(ntmp), 32'd2);
        chk("rst_ny", 32'(ny), 32'd2);
        chk("rst_tmp0", tmp_mem[0], 32'd204);
        chk("rst_tmp1", tmp_mem[1], 32'd492);
        chk("rst_y1", y_mem[1], 32'd984);
        chk("rst_tmp2", tmp_mem[2], 32'hDEADBEEF);
        chk("rst_y2", y_mem[2], 32'hDEADBEEF);
        run(-1, -1);
        chk_run(32'd204, 32'd288, 32'd408, 32'd576);

        for (int k = 0; k < 64; k++) begin
            a_mem[k] = 0;
            b_mem[k] = 0;
        end
        for (int k = 0; k < 8; k++) x_mem[k] = 0;
        a_mem[0] = 32'h80000000;
        x_mem[0] = 32'h80000000;
        alpha = 1; beta = 0;
        run(-1, -1);
        chk_run(32'd0, 32'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
